activation_serializer: RTL and testbench

Captures one parallel result vector from the dense/1x1-conv engine array, optionally applies ReLU, and streams the elements out one per cycle over a valid/ready handshake. It sits directly downstream of the dense layer. It frees the engine array to start its next accumulation pass while the previous results drain into the next layer's buffer or memory writer.

---
 rtl/activation_serializer.sv | 99 +++++++++
 tb/tb_activation_serializer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/activation_serializer.sv
// Captures one result vector from the dense engine array, with optional ReLU
// applied at capture, and streams it out one element per cycle over valid/ready.
module activation_serializer #(
  parameter int N           = 16,
  parameter int EngineCount = 1024,
  parameter int IndexBits   = $clog2(EngineCount)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic [N*EngineCount-1:0]   dense_i,
  input  logic                       relu_en_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [N-1:0]               out_data_o,
  output logic [IndexBits-1:0]       out_index_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic                       drop_o
);

  // state  | meaning
  // IDLE   | no vector held, waiting for load_i
  // STREAM | vector held, presenting buffer[index] until the last element is taken
  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  logic [IndexBits-1:0] index;
  logic [N-1:0]         buffer [EngineCount];
  logic                 handshake;
  logic                 at_last;
  logic                 take_load;

  function automatic logic [N-1:0] capture(input logic [N-1:0] v, input logic relu);
    return (relu && v[N-1]) ? '0 : v;
  endfunction

  assign at_last   = (index == IndexBits'(EngineCount - 1));
  assign handshake = out_valid_o & out_ready_i;
  // A load is only safe once nothing of the held vector remains to be sent.
  assign take_load = load_i & ((state == IDLE) | (handshake & at_last));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      index       <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      drop_o      <= 1'b0;
    end else begin
      drop_o <= load_i & ~take_load;
      case (state)
        IDLE: begin
          if (load_i) begin
            state       <= STREAM;
            index       <= '0;
            out_valid_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (!at_last) begin
              index <= index + IndexBits'(1);
            end else if (load_i) begin
              index <= '0;
            end else begin
              state       <= IDLE;
              index       <= '0;
              out_valid_o <= 1'b0;
              busy_o      <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          index       <= '0;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  // Holding buffer carries no reset; its contents are meaningless until a load.
  always_ff @(posedge clk_i) begin
    if (take_load) begin
      for (int i = 0; i < EngineCount; i++) begin
        buffer[i] <= capture(dense_i[i*N +: N], relu_en_i);
      end
    end
  end

  // Gating on the registered valid makes an async reset blank these at once.
  assign out_data_o  = out_valid_o ? buffer[index] : '0;
  assign out_index_o = out_valid_o ? index : '0;
  assign out_last_o  = out_valid_o & at_last;

endmodule

// File: tb/tb_activation_serializer.sv
// Directed bench for activation_serializer with N=16, EngineCount=4;
// expected values are hand-computed constants.
module tb_activation_serializer;
  localparam int N  = 16;
  localparam int EC = 4;
  localparam int IB = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            load_i;
  logic [N*EC-1:0] dense_i;
  logic            relu_en_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [N-1:0]    out_data_o;
  logic [IB-1:0]   out_index_o;
  logic            out_last_o;
  logic            busy_o;
  logic            drop_o;

  int n_cmp = 0;
  int n_err = 0;

  activation_serializer #(.N(N), .EngineCount(EC), .IndexBits(IB)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_i),
    .dense_i     (dense_i),
    .relu_en_i   (relu_en_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_index_o (out_index_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .drop_o      (drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Element 0 occupies the least significant slice.
  task automatic set_vec(input logic [N-1:0] e0, e1, e2, e3);
    dense_i = {e3, e2, e1, e0};
  endtask

  task automatic check_elem(input string tag, input logic [IB-1:0] idx, input logic [N-1:0] val);
    check({tag, " valid"}, 32'(out_valid_o), 32'd1);
    check({tag, " index"}, 32'(out_index_o), 32'(idx));
    check({tag, " data"},  32'(out_data_o),  32'(val));
    check({tag, " last"},  32'(out_last_o),  32'(idx == IB'(EC - 1)));
    check({tag, " busy"},  32'(busy_o),      32'd1);
  endtask

  logic [N-1:0] relu_exp [EC] = '{16'h0000, 16'h0007, 16'h0000, 16'h0000};
  logic [N-1:0] pass_exp [EC] = '{16'hFFFB, 16'h0007, 16'h0000, 16'h8000};
  logic         ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int e;
    rst_i       = 1'b1;
    load_i      = 1'b0;
    relu_en_i   = 1'b0;
    out_ready_i = 1'b1;
    dense_i     = '0;

    // reset and idle
    repeat (3) step();
    check("rst valid", 32'(out_valid_o), 32'd0);
    check("rst data",  32'(out_data_o),  32'd0);
    check("rst index", 32'(out_index_o), 32'd0);
    check("rst last",  32'(out_last_o),  32'd0);
    check("rst busy",  32'(busy_o),      32'd0);
    check("rst drop",  32'(drop_o),      32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle valid", 32'(out_valid_o), 32'd0);
    end

    // ReLU capture, ready always high
    set_vec(16'hFFFB, 16'h0007, 16'h0000, 16'h8000);
    relu_en_i = 1'b1;
    load_i    = 1'b1;
    step();
    load_i    = 1'b0;
    relu_en_i = 1'b0;
    for (int k = 0; k < EC; k++) begin
      check_elem("relu", IB'(k), relu_exp[k]);
      step();
    end
    check("relu busy after", 32'(busy_o),      32'd0);
    check("relu valid after", 32'(out_valid_o), 32'd0);
    check("relu data after", 32'(out_data_o),  32'd0);

    // pass-through with backpressure
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    e = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready_i = ready_pat[k];
      check_elem("bp", IB'(e), pass_exp[e]);
      step();
      if (ready_pat[k]) e++;
    end
    out_ready_i = 1'b1;
    check("bp count", 32'(e), 32'd4);
    check("bp busy after", 32'(busy_o), 32'd0);

    // rejected load while streaming
    set_vec(16'd9, 16'd9, 16'd9, 16'd9);
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    check("rej drop idle", 32'(drop_o), 32'd0);
    check_elem("rej0", 2'd0, 16'd9);
    step();
    check_elem("rej1", 2'd1, 16'd9);
    set_vec(16'd1, 16'd2, 16'd3, 16'd4);
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    check("rej drop pulse", 32'(drop_o), 32'd1);
    check_elem("rej2", 2'd2, 16'd9);
    step();
    check("rej drop clear", 32'(drop_o), 32'd0);
    check_elem("rej3", 2'd3, 16'd9);
    step();
    check("rej busy after", 32'(busy_o), 32'd0);
    check("rej drop end",   32'(drop_o), 32'd0);

    // back-to-back load on the final handshake
    set_vec(16'd9, 16'd9, 16'd9, 16'd9);
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    repeat (3) step();
    check_elem("b2b prev last", 2'd3, 16'd9);
    set_vec(16'd1, 16'd2, 16'd3, 16'd4);
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    check("b2b drop", 32'(drop_o), 32'd0);
    for (int k = 0; k < EC; k++) begin
      check_elem("b2b", IB'(k), N'(k + 1));
      step();
    end
    check("b2b busy after", 32'(busy_o), 32'd0);

    // async reset mid-stream
    set_vec(16'd5, 16'd6, 16'd7, 16'd8);
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    step();
    step();
    check_elem("arst pre", 2'd2, 16'd7);
    #2 rst_i = 1'b1;
    #1;
    check("arst valid", 32'(out_valid_o), 32'd0);
    check("arst busy",  32'(busy_o),      32'd0);
    check("arst data",  32'(out_data_o),  32'd0);
    check("arst index", 32'(out_index_o), 32'd0);
    step();
    step();
    rst_i = 1'b0;
    step();
    check("arst idle", 32'(out_valid_o), 32'd0);
    set_vec(16'd1, 16'd2, 16'd3, 16'd4);
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    check_elem("arst new0", 2'd0, 16'd1);
    step();
    check_elem("arst new1", 2'd1, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
